// File: rtl/wb_stage_if.sv
// MEM -> W bundle plus the regfile write port and debug trace.
// master drives the MEM side, slave is the writeback stage.
interface wb_stage_if;
    logic        stall_w;
    logic        flush_w;
    logic        valid_m;
    logic        regwrite_m;
    logic        memtoreg_m;
    logic [2:0]  loadtype_m;
    logic [4:0]  writereg_m;
    logic [31:0] aluout_m;
    logic [31:0] pc_m;
    logic [31:0] data_sram_rdata;

    logic        regwrite_w;
    logic [4:0]  writereg_w;
    logic [31:0] result_w;
    logic [31:0] pc_w;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    modport master (
        output stall_w, flush_w, valid_m, regwrite_m, memtoreg_m,
        output loadtype_m, writereg_m, aluout_m, pc_m, data_sram_rdata,
        input  regwrite_w, writereg_w, result_w, pc_w,
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
        input  debug_wb_rf_wdata
    );

    modport slave (
        input  stall_w, flush_w, valid_m, regwrite_m, memtoreg_m,
        input  loadtype_m, writereg_m, aluout_m, pc_m, data_sram_rdata,
        output regwrite_w, writereg_w, result_w, pc_w,
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
        output debug_wb_rf_wdata
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath: load alignment,
// SRAM read-data hold across stalls, regfile write port and debug trace.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input logic        clk,
    input logic        rst,
    wb_stage_if.slave  wb
);

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    logic        valid_q;
    logic        regwrite_q;
    logic        memtoreg_q;
    logic [2:0]  loadtype_q;
    logic [4:0]  writereg_q;
    logic [31:0] aluout_q;
    logic [31:0] pc_q;
    logic        hold_vld;
    logic [31:0] hold_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            loadtype_q <= 3'b000;
            writereg_q <= 5'd0;
            aluout_q   <= 32'd0;
            pc_q       <= RESET_PC;
            hold_vld   <= 1'b0;
            hold_data  <= 32'd0;
        end else if (wb.flush_w) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            hold_vld   <= 1'b0;
        end else if (wb.stall_w) begin
            // SRAM only presents the word in the first W cycle; latch it once
            if (!hold_vld) begin
                hold_data <= wb.data_sram_rdata;
                hold_vld  <= 1'b1;
            end
        end else begin
            valid_q    <= wb.valid_m;
            regwrite_q <= wb.regwrite_m;
            memtoreg_q <= wb.memtoreg_m;
            loadtype_q <= wb.loadtype_m;
            writereg_q <= wb.writereg_m;
            aluout_q   <= wb.aluout_m;
            pc_q       <= wb.pc_m;
            hold_vld   <= 1'b0;
        end
    end

    logic [31:0] raw;
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_comb begin
        raw      = hold_vld ? hold_data : wb.data_sram_rdata;
        off      = aluout_q[1:0];
        byte_sel = raw[8*off +: 8];
        half_sel = off[1] ? raw[31:16] : raw[15:0];
        case (loadtype_q)
            LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  load_data = {24'd0, byte_sel};
            LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  load_data = {16'd0, half_sel};
            LD_LW:   load_data = raw;
            default: load_data = raw;
        endcase
    end

    logic        we;
    logic [31:0] result;

    assign we     = valid_q & regwrite_q & (writereg_q != 5'd0);
    assign result = memtoreg_q ? load_data : aluout_q;

    assign wb.regwrite_w        = we;
    assign wb.writereg_w        = writereg_q;
    assign wb.result_w          = result;
    assign wb.pc_w              = pc_q;
    assign wb.debug_wb_pc       = pc_q;
    assign wb.debug_wb_rf_wen   = {4{we}};
    assign wb.debug_wb_rf_wnum  = writereg_q;
    assign wb.debug_wb_rf_wdata = result;

endmodule
